// File: rtl/add_serial_ctrl_if.sv
// Bundle of the operand-in, adder-side and result-out signals of add_serial_ctrl.
// The slave modport is the controller's view; the master modport is the environment's.
interface add_serial_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       add_en;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_sum;
    logic       busy;
    logic [7:0] done_cnt;

    modport slave (
        input  in_valid, in_a, in_b, add_out, res_ready,
        output in_ready, add_en, add_a, add_b, res_valid, res_sum, busy, done_cnt
    );

    modport master (
        output in_valid, in_a, in_b, add_out, res_ready,
        input  in_ready, add_en, add_a, add_b, res_valid, res_sum, busy, done_cnt
    );
endinterface

// File: rtl/add_serial_ctrl.sv
// Controller for a serial adder: buffers operand pairs in a small FIFO, launches one
// addition at a time, waits the fixed bit-serial latency, captures the sum and hands it
// to the consumer, then releases the adder back to its idle state.
module add_serial_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    add_serial_ctrl_if.slave  bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMR_LOAD = TW'(ADD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPT,
        S_OUT,
        S_REL
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_d;

    logic [15:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [7:0]      r_add_a;
    logic [7:0]      r_add_b;
    logic [7:0]      r_res_sum;
    logic [7:0]      r_done_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_capt;
    logic            w_accept;
    logic            w_add_en;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;

    // Next-state, timer and per-state strobes.
    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_pop     = 1'b0;
        w_capt    = 1'b0;
        w_accept  = 1'b0;
        w_add_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = S_START;
                end
            end
            S_START: begin
                w_add_en  = 1'b1;
                w_timer_d = TMR_LOAD;
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (r_timer == '0) begin
                    w_state_d = S_CAPT;
                end else begin
                    w_timer_d = r_timer - TW'(1);
                end
            end
            S_CAPT: begin
                w_capt    = 1'b1;
                w_state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    w_accept  = 1'b1;
                    w_state_d = S_REL;
                end
            end
            S_REL: begin
                // Second enable pulse moves the adder from DONE back to IDLE.
                w_add_en  = 1'b1;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // State register and wait timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // FIFO storage; a write during reset is harmless because the pointer does not advance.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    // Operand, result and transfer-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_res_sum  <= '0;
            r_done_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_add_a <= r_mem[r_rd_ptr][15:8];
                r_add_b <= r_mem[r_rd_ptr][7:0];
            end
            if (w_capt) begin
                r_res_sum <= bus.add_out;
            end
            if (w_accept) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.add_en    = w_add_en;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.res_valid = (r_state == S_OUT);
    assign bus.res_sum   = r_res_sum;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Directed bench for add_serial_ctrl with a behavioural serial-adder model.
module tb_add_serial_ctrl;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned ADD_CYCLES = 8;

    logic clk;
    logic rst;

    int unsigned vectors;
    int unsigned miscompares;
    logic [7:0]  exp_done;

    add_serial_ctrl_if bus ();

    add_serial_ctrl #(
        .DEPTH      (DEPTH),
        .ADD_CYCLES (ADD_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial adder model: started by an enable pulse while idle, the result appears
    // ADD_CYCLES+1 cycles after the start cycle and is held until the release pulse.
    // Before that the output carries a junk value so an early capture is visible.
    logic       m_run;
    logic       m_done;
    logic [7:0] m_sum;
    int         m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= 8'h00;
            m_cnt  <= 0;
        end else if (!m_run) begin
            if (bus.add_en) begin
                m_run <= 1'b1;
                m_cnt <= 1;
                m_sum <= bus.add_a + bus.add_b;
            end
        end else if (m_done && bus.add_en) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == ADD_CYCLES + 1) begin
                m_done <= 1'b1;
            end
        end
    end

    assign bus.add_out = m_done ? m_sum : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            chk("push_timeout", {31'd0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp_sum);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk({tag, "_timeout"}, {31'd0, bus.res_valid}, 32'd1);
        end
        chk({tag, "_sum"}, {24'd0, bus.res_sum}, {24'd0, exp_sum});
    endtask

    // Push, wait for the result (res_ready assumed high) and check the transfer count.
    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sum);
        push(a, b);
        wait_result(tag, exp_sum);
        @(negedge clk);
        exp_done = exp_done + 8'd1;
        chk({tag, "_done_cnt"}, {24'd0, bus.done_cnt}, {24'd0, exp_done});
    endtask

    initial begin
        int n;
        int bad;
        vectors       = 0;
        miscompares   = 0;
        exp_done      = 8'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.res_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_add_en", {31'd0, bus.add_en}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_sum", {24'd0, bus.res_sum}, 32'd0);
        chk("rst_done_cnt", {24'd0, bus.done_cnt}, 32'd0);
        chk("rst_add_a", {24'd0, bus.add_a}, 32'd0);
        chk("rst_add_b", {24'd0, bus.add_b}, 32'd0);

        // 0x03 + 0x05 with exact latencies.
        push(8'h03, 8'h05);
        @(negedge clk);
        chk("t1_idle_add_en", {31'd0, bus.add_en}, 32'd0);
        chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("t1_start_add_en", {31'd0, bus.add_en}, 32'd1);
        chk("t1_start_busy", {31'd0, bus.busy}, 32'd1);
        chk("t1_add_a", {24'd0, bus.add_a}, 32'h03);
        chk("t1_add_b", {24'd0, bus.add_b}, 32'h05);
        @(negedge clk);
        chk("t1_pulse_width", {31'd0, bus.add_en}, 32'd0);
        n = 1;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_res_latency", n, ADD_CYCLES + 2);
        chk("t1_res_sum", {24'd0, bus.res_sum}, 32'h08);
        @(negedge clk);
        chk("t1_rel_add_en", {31'd0, bus.add_en}, 32'd1);
        chk("t1_rel_res_valid", {31'd0, bus.res_valid}, 32'd0);
        exp_done = 8'd1;
        chk("t1_done_cnt", {24'd0, bus.done_cnt}, 32'd1);
        @(negedge clk);
        chk("t1_back_idle", {31'd0, bus.busy}, 32'd0);
        chk("t1_idle_add_en2", {31'd0, bus.add_en}, 32'd0);

        // Modulo-256 sums.
        run_one("wrap_ff01", 8'hFF, 8'h01, 8'h00);
        run_one("wrap_8080", 8'h80, 8'h80, 8'h00);

        // Back-pressure on the result: everything must hold for 20 cycles.
        bus.res_ready = 1'b0;
        push(8'h07, 8'h09);
        push(8'h01, 8'h02);
        wait_result("hold", 8'h10);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_sum !== 8'h10 || bus.add_en) begin
                bad++;
            end
        end
        chk("hold_stable", bad, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("hold_rel_add_en", {31'd0, bus.add_en}, 32'd1);
        chk("hold_rel_res_valid", {31'd0, bus.res_valid}, 32'd0);
        exp_done = exp_done + 8'd1;
        chk("hold_done_cnt", {24'd0, bus.done_cnt}, {24'd0, exp_done});
        @(negedge clk);
        chk("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("hold_next_start", {31'd0, bus.add_en}, 32'd1);
        chk("hold_next_a", {24'd0, bus.add_a}, 32'h01);
        chk("hold_next_b", {24'd0, bus.add_b}, 32'h02);
        wait_result("hold_next", 8'h03);
        @(negedge clk);
        exp_done = exp_done + 8'd1;
        chk("hold_next_done", {24'd0, bus.done_cnt}, {24'd0, exp_done});

        // Five back-to-back pushes: first is popped at once, the other four fill the FIFO.
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(i);
            bus.in_b     = 8'(i);
            @(negedge clk);
            chk("burst_ready_before_push", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("burst_full_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("burst_busy", {31'd0, bus.busy}, 32'd1);
        wait_result("burst1", 8'h02);
        wait_result("burst2", 8'h04);
        wait_result("burst3", 8'h06);
        wait_result("burst4", 8'h08);
        wait_result("burst5", 8'h0A);
        @(negedge clk);
        exp_done = exp_done + 8'd5;
        chk("burst_done_cnt", {24'd0, bus.done_cnt}, {24'd0, exp_done});
        chk("burst_ready_after", {31'd0, bus.in_ready}, 32'd1);

        // Reset in the middle of the wait phase, with a push offered during reset.
        push(8'h11, 8'h22);
        n = 0;
        @(negedge clk);
        while (!bus.add_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_start_seen", {31'd0, bus.add_en}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h55;
        bus.in_b     = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("mid_rst_done_cnt", {24'd0, bus.done_cnt}, 32'd0);
        chk("mid_rst_res_sum", {24'd0, bus.res_sum}, 32'd0);
        chk("mid_rst_add_a", {24'd0, bus.add_a}, 32'd0);
        @(negedge clk);
        chk("rst_push_ignored", {31'd0, bus.busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy) begin
                bad++;
            end
        end
        chk("mid_rst_quiet", bad, 0);
        exp_done = 8'd0;
        run_one("post_rst", 8'h10, 8'h20, 8'h30);

        // Run the transfer count up to 255 and then over the wrap.
        bad = 0;
        for (int i = 0; i < 254; i++) begin
            push(8'(i), 8'h03);
            n = 0;
            @(negedge clk);
            while (!bus.res_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!bus.res_valid || bus.res_sum !== 8'(i + 3)) begin
                bad++;
            end
            @(negedge clk);
        end
        chk("many_sums", bad, 0);
        chk("done_cnt_255", {24'd0, bus.done_cnt}, 32'hFF);
        exp_done = 8'hFF;
        run_one("wrap_cnt", 8'h40, 8'h02, 8'h42);
        chk("done_cnt_wrapped", {24'd0, bus.done_cnt}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
